// File: rtl/pwm_pkg.sv
// pwm_pkg: channel mode encoding shared by the multi-channel PWM driver
package pwm_pkg;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_STATIC  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED output with config, breathe ramp, boundary latch and output register
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 we,
  input  logic                 tick,
  input  logic [1:0]           mode,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic [PWM_WIDTH-1:0] pwm,
  output logic                 led
);
  localparam logic [PWM_WIDTH-1:0] MAX = '1;
  localparam logic [PWM_WIDTH-1:0] ONE = PWM_WIDTH'(1);
  mode_t                mode_cfg, mode_act;
  logic [PWM_WIDTH-1:0] duty_cfg, duty_act, level;
  logic                 dir;
  // config writes win over the breathe step; a breathe write also sets the phase
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_cfg <= MODE_OFF;
      duty_cfg <= '0;
      level    <= '0;
      dir      <= 1'b1;
    end else if (we) begin
      mode_cfg <= mode_t'(mode);
      duty_cfg <= duty;
      if (mode_t'(mode) == MODE_BREATHE) begin
        level <= duty;
        dir   <= 1'b1;
      end
    end else if (tick && mode_cfg == MODE_BREATHE) begin
      level <= dir ? (level == MAX ? MAX - ONE : level + ONE) : (level == '0 ? ONE : level - ONE);
      dir   <= dir ? level != MAX : level == '0;
    end
  end
  // active settings change only at the period boundary so pulses are never cut short
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_act <= MODE_OFF;
      duty_act <= '0;
      led      <= 1'b0;
    end else begin
      if (pwm == MAX) begin
        mode_act <= mode_cfg;
        duty_act <= mode_cfg == MODE_OFF ? '0 : mode_cfg == MODE_BREATHE ? level : duty_cfg;
      end
      led <= mode_act == MODE_ON || (mode_act != MODE_OFF && duty_act > pwm);
    end
  end
endmodule

// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi: shared PWM counter and ramp prescaler driving CHANNELS LED outputs
module pwm_breathe_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int PWM_WIDTH = 8,
  parameter int RAMP_DIV  = 14,
  localparam int AW       = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [1:0]           cfg_mode,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  output logic [CHANNELS-1:0]  LED
);
  logic [PWM_WIDTH-1:0] pwm;
  logic [RAMP_DIV-1:0]  presc;
  logic                 tick;
  assign tick = &presc;
  // free-running period counter and ramp prescaler
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm   <= '0;
      presc <= '0;
    end else begin
      pwm   <= pwm + PWM_WIDTH'(1);
      presc <= presc + RAMP_DIV'(1);
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .we   (cfg_we && cfg_addr == AW'(i)),
      .tick (tick),
      .mode (cfg_mode),
      .duty (cfg_duty),
      .pwm  (pwm),
      .led  (LED[i])
    );
  end
endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi: randomized and directed checks against a cycle-count based reference model
module tb_pwm_breathe_multi;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_duty = '0;
  logic [2:0] LED;
  int checks = 0;
  int failures = 0;

  pwm_breathe_multi #(.CHANNELS(3), .PWM_WIDTH(4), .RAMP_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .LED(LED)
  );

  always #5 CLK = ~CLK;

  // reference: n = cycles since reset, pos = place on a 30-step triangle
  int n;
  int mc[3], ma[3], dc[3], da[3], pos[3];
  logic [2:0] el;

  function automatic int lvl(input int p);
    return p <= 15 ? p : 30 - p;
  endfunction

  task automatic cyc();
    int pv;
    if (RST) begin
      n = 0;
      el = '0;
      for (int i = 0; i < 3; i++) begin
        mc[i] = 0; ma[i] = 0; dc[i] = 0; da[i] = 0; pos[i] = 0;
      end
    end else begin
      pv = n % 16;
      for (int i = 0; i < 3; i++) begin
        el[i] = (ma[i] == 1) || (ma[i] != 0 && da[i] > pv);
        if (pv == 15) begin
          ma[i] = mc[i];
          da[i] = mc[i] == 0 ? 0 : mc[i] == 3 ? lvl(pos[i]) : dc[i];
        end
        if (cfg_we && int'(cfg_addr) == i) begin
          mc[i] = int'(cfg_mode);
          dc[i] = int'(cfg_duty);
          if (cfg_mode == 2'd3) pos[i] = int'(cfg_duty);
        end else if (n % 4 == 3 && mc[i] == 3) begin
          pos[i] = (pos[i] + 1) % 30;
        end
      end
      n++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input int m, input int d);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_mode = 2'(m);
    cfg_duty = 4'(d);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (LED !== 3'b000) begin failures++; $display("FAIL reset_hold LED=%b expected=000", LED); end
    end
    RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if (LED !== 3'b000) begin failures++; $display("FAIL reset_idle k=%0d LED=%b expected=000", k, LED); end
    end
    wr(3, 1, 15);
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if (LED !== 3'b000) begin failures++; $display("FAIL bad_addr k=%0d LED=%b expected=000", k, LED); end
    end
  endtask

  task automatic test_static();
    int duties[3] = '{4, 0, 15};
    int cnt;
    foreach (duties[j]) begin
      wr(0, 2, duties[j]);
      for (int k = 0; k < 40; k++) begin
        cyc();
        checks++;
        if (LED !== el) begin failures++; $display("FAIL static_model d=%0d LED=%b expected=%b", duties[j], LED, el); end
      end
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        cyc();
        cnt += int'(LED[0]);
      end
      checks++;
      if (cnt != duties[j]) begin failures++; $display("FAIL static_width got=%0d expected=%0d", cnt, duties[j]); end
    end
    wr(0, 2, 4);
    for (int k = 0; k < 40; k++) cyc();
    while (n % 16 != 0) cyc();
    checks++;
    if (LED[0] !== 1'b0) begin failures++; $display("FAIL static_pre_rise LED0=%b expected=0", LED[0]); end
    cyc();
    checks++;
    if (LED[0] !== 1'b1) begin failures++; $display("FAIL static_rise LED0=%b expected=1", LED[0]); end
  endtask

  task automatic test_on_off();
    int cnt;
    wr(1, 1, 0);
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if (LED !== el) begin failures++; $display("FAIL on_model LED=%b expected=%b", LED, el); end
    end
    cnt = 0;
    for (int k = 0; k < 16; k++) begin cyc(); cnt += int'(LED[1]); end
    checks++;
    if (cnt != 16) begin failures++; $display("FAIL on_width got=%0d expected=16", cnt); end
    wr(1, 0, 9);
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if (LED !== el) begin failures++; $display("FAIL off_model LED=%b expected=%b", LED, el); end
    end
    checks++;
    if (LED[1] !== 1'b0) begin failures++; $display("FAIL off_level LED1=%b expected=0", LED[1]); end
  endtask

  task automatic test_breathe();
    wr(2, 3, 0);
    for (int k = 0; k < 16 * 36; k++) begin
      cyc();
      checks++;
      if (LED !== el) begin failures++; $display("FAIL breathe_model k=%0d LED=%b expected=%b", k, LED, el); end
    end
  endtask

  task automatic test_write_vs_tick();
    int cnt;
    while (n % 4 != 3) cyc();
    wr(0, 3, 15);
    while (n % 4 != 3) cyc();
    wr(1, 3, 1);
    for (int k = 0; k < 32; k++) begin
      cyc();
      checks++;
      if (LED !== el) begin failures++; $display("FAIL antiphase_model LED=%b expected=%b", LED, el); end
    end
    while (n % 16 != 0) cyc();
    for (int p = 0; p < 10; p++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        cyc();
        cnt += int'(LED[0]) + int'(LED[1]);
        checks++;
        if (LED !== el) begin failures++; $display("FAIL antiphase_cycle LED=%b expected=%b", LED, el); end
      end
      checks++;
      if (cnt != 15) begin failures++; $display("FAIL antiphase_sum period=%0d got=%0d expected=15", p, cnt); end
    end
  endtask

  task automatic test_boundary();
    int cnt;
    int guard;
    wr(0, 2, 2);
    for (int k = 0; k < 40; k++) cyc();
    while (n % 16 != 15) cyc();
    wr(0, 2, 8);
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) begin cyc(); cnt += int'(LED[0]); end
      checks++;
      if (cnt != (p == 0 ? 2 : 8)) begin failures++; $display("FAIL boundary_width period=%0d got=%0d expected=%0d", p, cnt, p == 0 ? 2 : 8); end
    end
    guard = 0;
    while (LED[0] !== 1'b1 && guard < 40) begin cyc(); guard++; end
    checks++;
    if (guard >= 40) begin failures++; $display("FAIL pulse_wait LED0=%b expected=1", LED[0]); end
    RST = 1'b1;
    cyc();
    checks++;
    if (LED !== 3'b000) begin failures++; $display("FAIL mid_reset LED=%b expected=000", LED); end
    cyc();
    RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if (LED !== 3'b000) begin failures++; $display("FAIL post_reset LED=%b expected=000", LED); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_duty = 4'($urandom_range(0, 15));
      cyc();
      checks++;
      if (LED !== el) begin failures++; $display("FAIL random k=%0d LED=%b expected=%b", k, LED, el); end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_on_off();
    test_breathe();
    test_write_vs_tick();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
